// File: rtl/vedic_pkg.sv
// Shared types and the 2x2 Urdhva-Tiryagbhyam cell for the Vedic multiplier tree.
package vedic_pkg;

    localparam int VEDIC_DW = 8;

    typedef logic [7:0]  operand_t;
    typedef logic [15:0] product_t;
    typedef logic [3:0]  nibble_t;
    typedef logic [7:0]  byte4x4_t;

    function automatic nibble_t vedic_mul2(input logic [1:0] a, input logic [1:0] b);
        logic t_lo;
        logic t_hi;
        logic c;
        logic hh;
        nibble_t p;
        t_lo = a[1] & b[0];
        t_hi = a[0] & b[1];
        c    = t_lo & t_hi;
        hh   = a[1] & b[1];
        p[0] = a[0] & b[0];
        p[1] = t_lo ^ t_hi;
        p[2] = hh ^ c;
        p[3] = hh & c;
        return p;
    endfunction

endpackage

// File: rtl/vedic_mul_4x4.sv
// Combinational 4x4 Vedic product from four 2x2 cells; no state, no backpressure.
module vedic_mul_4x4
    import vedic_pkg::*;
(
    input  nibble_t  a_i,
    input  nibble_t  b_i,
    output byte4x4_t p_o
);

    nibble_t    ll;
    nibble_t    hl;
    nibble_t    lh;
    nibble_t    hh;
    logic [4:0] mid;

    assign ll  = vedic_mul2(a_i[1:0], b_i[1:0]);
    assign hl  = vedic_mul2(a_i[3:2], b_i[1:0]);
    assign lh  = vedic_mul2(a_i[1:0], b_i[3:2]);
    assign hh  = vedic_mul2(a_i[3:2], b_i[3:2]);

    // Cross terms can carry into a fifth bit before the shift by 2.
    assign mid = {1'b0, hl} + {1'b0, lh};
    assign p_o = {hh, ll} + {1'b0, mid, 2'b00};

endmodule

// File: rtl/vedic_multiplier.sv
// Registered 8x8 Vedic multiplier, 1-cycle latency (2 with VEDIC_MULT_PIPE_EN), no backpressure.
// VEDIC_MULT_PIPE_EN registers the four 4x4 partial products before the final add.
module vedic_multiplier
    import vedic_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   inData_A,
    input  logic [DATA_WIDTH-1:0]   inData_B,
    output logic                    out_valid,
    output logic [2*DATA_WIDTH-1:0] outData_C
);

    generate
        if (DATA_WIDTH != VEDIC_DW) begin : g_bad_width
            $error("vedic_multiplier supports only DATA_WIDTH = 8");
        end
    endgenerate

    operand_t a;
    operand_t b;
    byte4x4_t ll_d;
    byte4x4_t hl_d;
    byte4x4_t lh_d;
    byte4x4_t hh_d;

    assign a = inData_A;
    assign b = inData_B;

    vedic_mul_4x4 u_ll (.a_i(a[3:0]), .b_i(b[3:0]), .p_o(ll_d));
    vedic_mul_4x4 u_hl (.a_i(a[7:4]), .b_i(b[3:0]), .p_o(hl_d));
    vedic_mul_4x4 u_lh (.a_i(a[3:0]), .b_i(b[7:4]), .p_o(lh_d));
    vedic_mul_4x4 u_hh (.a_i(a[7:4]), .b_i(b[7:4]), .p_o(hh_d));

    byte4x4_t ll_s;
    byte4x4_t hl_s;
    byte4x4_t lh_s;
    byte4x4_t hh_s;
    logic     cap_vld;

`ifdef VEDIC_MULT_PIPE_EN
    byte4x4_t ll_q;
    byte4x4_t hl_q;
    byte4x4_t lh_q;
    byte4x4_t hh_q;
    logic     vld1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ll_q   <= '0;
            hl_q   <= '0;
            lh_q   <= '0;
            hh_q   <= '0;
            vld1_q <= 1'b0;
        end else begin
            vld1_q <= in_valid;
            if (in_valid) begin
                ll_q <= ll_d;
                hl_q <= hl_d;
                lh_q <= lh_d;
                hh_q <= hh_d;
            end
        end
    end

    assign ll_s    = ll_q;
    assign hl_s    = hl_q;
    assign lh_s    = lh_q;
    assign hh_s    = hh_q;
    assign cap_vld = vld1_q;
`else
    assign ll_s    = ll_d;
    assign hl_s    = hl_d;
    assign lh_s    = lh_d;
    assign hh_s    = hh_d;
    assign cap_vld = in_valid;
`endif

    logic [8:0] mid_s;
    product_t   prod_d;
    product_t   prod_q;
    logic       vld_q;

    // HH and LL occupy disjoint bit ranges, so only the middle term needs a real add.
    assign mid_s  = {1'b0, hl_s} + {1'b0, lh_s};
    assign prod_d = {hh_s, ll_s} + {3'b000, mid_s, 4'b0000};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= cap_vld;
            if (cap_vld) begin
                prod_q <= prod_d;
            end
        end
    end

    assign out_valid = vld_q;
    assign outData_C = prod_q;

endmodule

// File: tb/tb_vedic_multiplier.sv
// Directed and random checks of vedic_multiplier at either configured latency.
module tb_vedic_multiplier;

`ifdef VEDIC_MULT_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  inData_A;
    logic [7:0]  inData_B;
    logic        out_valid;
    logic [15:0] outData_C;

    int tests = 0;
    int fails = 0;

    vedic_multiplier #(.DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .inData_A  (inData_A),
        .inData_B  (inData_B),
        .out_valid (out_valid),
        .outData_C (outData_C)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one input set, then step past the next rising edge.
    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b);
        in_valid = v;
        inData_A = a;
        inData_B = b;
        @(posedge clk);
        #1;
    endtask

    task automatic single(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp);
        drive(1'b1, a, b);
        repeat (LAT - 1) drive(1'b0, 8'd0, 8'd0);
        chk({tag, "_vld"}, {15'd0, out_valid}, 16'd1);
        chk(tag, outData_C, exp);
    endtask

    logic [7:0]  sa [5] = '{8'd12, 8'd100, 8'd255, 8'd128, 8'd99};
    logic [7:0]  sb [5] = '{8'd13, 8'd7,   8'd2,   8'd128, 8'd101};
    logic [15:0] se [5] = '{16'd156, 16'd700, 16'd510, 16'd16384, 16'd9999};

    logic        q_v [$];
    logic [15:0] q_p [$];
    logic [15:0] last_p;

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        inData_A = 8'd0;
        inData_B = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_data", outData_C, 16'd0);
        chk("reset_vld", {15'd0, out_valid}, 16'd0);
        rst = 1'b0;

        single("a0_b200",   8'd0,   8'd200, 16'd0);
        single("a255_b255", 8'd255, 8'd255, 16'd65025);
        single("a1_b255",   8'd1,   8'd255, 16'd255);
        single("a15_b15",   8'd15,  8'd15,  16'd225);
        single("a16_b16",   8'd16,  8'd16,  16'd256);
        single("a170_b85",  8'd170, 8'd85,  16'd14450);
        single("a3_b3",     8'd3,   8'd3,   16'd9);

        // Asynchronous reset between edges clears outputs immediately.
        #2 rst = 1'b1;
        #1;
        chk("async_rst_data", outData_C, 16'd0);
        chk("async_rst_vld", {15'd0, out_valid}, 16'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) begin
            drive(1'b0, 8'd77, 8'd3);
            chk("post_rst_idle_vld", {15'd0, out_valid}, 16'd0);
        end

        for (int i = 0; i < 5 + LAT - 1; i++) begin
            if (i < 5) drive(1'b1, sa[i], sb[i]);
            else       drive(1'b0, 8'd0, 8'd0);
            if (i - LAT + 1 >= 0) begin
                chk("stream_vld", {15'd0, out_valid}, 16'd1);
                chk("stream_data", outData_C, se[i-LAT+1]);
            end
        end

        repeat (3) begin
            drive(1'b0, 8'd201, 8'd9);
            chk("hold_vld", {15'd0, out_valid}, 16'd0);
            chk("hold_data", outData_C, 16'd9999);
        end

        // Product in flight when reset hits must never surface.
        drive(1'b1, 8'd7, 8'd9);
        in_valid = 1'b1;
        inData_A = 8'd11;
        inData_B = 8'd13;
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_data", outData_C, 16'd0);
        chk("midrst_vld", {15'd0, out_valid}, 16'd0);
        rst = 1'b0;
        repeat (3) begin
            drive(1'b0, 8'd0, 8'd0);
            chk("midrst_after_vld", {15'd0, out_valid}, 16'd0);
            chk("midrst_after_data", outData_C, 16'd0);
        end

        last_p = 16'd0;
        for (int n = 0; n < 10000 + LAT; n++) begin
            logic       v;
            logic [7:0] a;
            logic [7:0] b;
            v = (n < 10000) ? ($urandom_range(3, 0) != 0) : 1'b0;
            a = 8'($urandom);
            b = 8'($urandom);
            q_v.push_back(v);
            q_p.push_back(16'(a) * 16'(b));
            drive(v, a, b);
            if (q_v.size() == LAT) begin
                logic        ev;
                logic [15:0] ep;
                ev = q_v.pop_front();
                ep = q_p.pop_front();
                if (ev) last_p = ep;
                chk("rand_vld", {15'd0, out_valid}, {15'd0, ev});
                chk("rand_data", outData_C, last_p);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vedic_multiplier.md
# vedic_multiplier

Registered 8×8 unsigned multiplier built on the Vedic (Urdhva-Tiryagbhyam) decomposition: 2×2 cells form 4×4 products, and four 4×4 products form the 8×8 result. It is the multiply primitive of the matrix-multiplier datapath and feeds the accumulate stage. A valid bit travels with the data so upstream and downstream logic can gate accumulation.

## Interface
- `DATA_WIDTH`, default 8: operand width. The only supported value is 8. Elaboration fails with `$error` for any other value.
- `clk`, input, 1: the single clock. All state updates on its rising edge.
- `rst`, input, 1: reset, **asynchronous, active-high**.
- `in_valid`, input, 1: `inData_A` and `inData_B` hold a valid operand pair this cycle.
- `inData_A`, input, DATA_WIDTH: unsigned multiplicand.
- `inData_B`, input, DATA_WIDTH: unsigned multiplier.
- `out_valid`, output, 1: `outData_C` holds a valid product.
- `outData_C`, output, 2*DATA_WIDTH: unsigned product.

## Operation
- **2×2 cell.** For a = {a1,a0} and b = {b1,b0}:
  - p0 = a0&b0
  - p1 = (a1&b0)^(a0&b1), carry c = (a1&b0)&(a0&b1)
  - p2 = (a1&b1)^c
  - p3 = (a1&b1)&c
  - Result is a 4-bit value.
- **4×4 from 2×2.** Split each operand into high and low halves: H and L.
  - Cross term: sum = LH×LL·… expressed as p = LL + ((HL + LH) << 2) + (HH << 4), where each term is a 2×2 product.
  - Use ripple/half-adder sums with exact widths, giving an 8-bit result.
- **8×8 from 4×4.** Same decomposition on nibbles: p = LL + ((HL+LH) << 4) + (HH << 8).
  - The middle sum is 9 bits wide.
  - The final sum is 16 bits wide.
  - No truncation or overflow is possible; the result equals the exact A×B.
- All arithmetic is unsigned. No signed mode.
- **Capture.**
  - When `in_valid` is 1, the product is registered into `outData_C`.
  - When `in_valid` is 0, `outData_C` holds its previous value.
  - `out_valid` is the registered `in_valid`.
- No backpressure. A new operand pair can be accepted every cycle.

## Timing
- **Reset values:** `outData_C` = 0 and `out_valid` = 0, asynchronously on `rst` assertion. They stay in that state while `rst` is high.
- **Latency:** 1 cycle (default build). Operands sampled at edge N produce `outData_C`/`out_valid` valid after edge N.
- **Throughput:** 1 product per cycle.
- **Back-to-back valids** produce back-to-back results, in order.
- **Reset mid-operation:** any in-flight product is discarded. The first valid input after `rst` deasserts produces the first `out_valid`.
- The combinational path from inputs to the first register is the complete 8×8 Vedic tree.

## Configuration
- **`VEDIC_MULT_PIPE_EN` defined:** adds a pipeline register after the four 4×4 partial products.
  - The partial products and the valid bit are registered.
  - The three-term final addition is done in the second stage.
  - Latency is 2 cycles. Reset clears the intermediate registers and valid bits to 0.
- **`VEDIC_MULT_PIPE_EN` undefined:** single register stage with latency 1, as described above.
- Throughput is 1 per cycle in both builds.

## Structure
- **Package `vedic_pkg`:**
  - `localparam VEDIC_DW = 8`
  - typedefs `operand_t` (logic [7:0]), `product_t` (logic [15:0]), `nibble_t` (logic [3:0]), `byte4x4_t` (logic [7:0])
  - function `vedic_mul2` implementing the 2×2 cell.
- **Sub-module `vedic_mul_4x4`:**
  - Purely combinational, nibble_t inputs and byte4x4_t output.
  - Built from four `vedic_mul2` calls plus explicit adders.
  - Instantiated four times by the top module.
- **Top `vedic_multiplier`:** contains the 8×8 combining adders, the optional pipeline stage, and the output registers.

## Test plan
- **Reset check:** assert `rst` asynchronously between clock edges -> `outData_C` = 0 and `out_valid` = 0 immediately, and no `out_valid` until the next `in_valid`.
- **Corner operands:** A=0, B=200 -> 0; A=255, B=255 -> 65025; A=1, B=255 -> 255.
- **Nibble-boundary carries:** A=15, B=15 -> 225; A=16, B=16 -> 256; A=170, B=85 -> 14450; A=3, B=3 -> 9 (2×2 carry path).
- **Streaming:** apply 5 back-to-back valid pairs, (12,13), (100,7), (255,2), (128,128), (99,101) -> results 156, 700, 510, 16384, 9999 on consecutive cycles at the configured latency.
- **Hold and mid-stream reset:** with `in_valid`=0 the output holds its last product and `out_valid`=0. Assert `rst` with a product in flight -> it never appears.
- **Random sweep:** 10,000 random pairs in both macro builds -> `outData_C` == A*B on every `out_valid`, at latency 1 or 2 respectively.
